// File: rtl/sd_arb_pkg.sv
// Shared types and bus widths for the SD sector-port arbiter.
package sd_arb_pkg;
  localparam int unsigned SD_LBA_W  = 32;
  localparam int unsigned SD_ADDR_W = 9;
  localparam int unsigned SD_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester after i_ptr wins.
module rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic            o_hit,
  output logic [IdxW-1:0] o_idx
);
  logic [IdxW-1:0] w_cand;

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IdxW'((32'(i_ptr) + 32'(k)) % N);
      if (i_req[w_cand]) begin
        o_hit = 1'b1;
        o_idx = w_cand;
      end
    end
  end
endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one user_io SD sector port among N_CLIENTS requesters.
// Optional request timeout enabled by defining SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                            i_clk_sys,
  input  logic                            i_reset_n,
  input  logic [SD_LBA_W*N_CLIENTS-1:0]   i_cl_lba,
  input  logic [N_CLIENTS-1:0]            i_cl_rd,
  input  logic [N_CLIENTS-1:0]            i_cl_wr,
  output logic [N_CLIENTS-1:0]            o_cl_done,
  output logic [N_CLIENTS-1:0]            o_cl_err,
  output logic [SD_ADDR_W-1:0]            o_cl_buff_addr,
  output logic [SD_DATA_W-1:0]            o_cl_buff_dout,
  output logic [N_CLIENTS-1:0]            o_cl_buff_wr,
  output logic [N_CLIENTS-1:0]            o_cl_din_strobe,
  input  logic [SD_DATA_W*N_CLIENTS-1:0]  i_cl_buff_din,
  output logic [SD_LBA_W-1:0]             o_sd_lba,
  output logic                            o_sd_rd,
  output logic                            o_sd_wr,
  input  logic                            i_sd_ack,
  input  logic [SD_ADDR_W-1:0]            i_sd_buff_addr,
  input  logic [SD_DATA_W-1:0]            i_sd_buff_dout,
  input  logic                            i_sd_buff_wr,
  input  logic                            i_sd_din_strobe,
  output logic [SD_DATA_W-1:0]            o_sd_buff_din
);
  localparam int unsigned IdxW = $clog2(N_CLIENTS);

  if (N_CLIENTS < 2 || N_CLIENTS > 4 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("sd_sector_arbiter: illegal parameter value");
  end

  arb_state_t             r_state, w_state_nxt;
  logic [IdxW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [IdxW-1:0]        r_grant_idx, w_grant_idx_nxt;
  logic [N_CLIENTS-1:0]   r_grant_oh, w_grant_oh_nxt;
  logic [SD_LBA_W-1:0]    r_sd_lba, w_sd_lba_nxt;
  logic                   r_sd_rd, w_sd_rd_nxt;
  logic                   r_sd_wr, w_sd_wr_nxt;
  logic [N_CLIENTS-1:0]   r_cl_done, w_cl_done_nxt;
  logic                   w_hit;
  logic [IdxW-1:0]        w_pick;
  logic [SD_DATA_W-1:0]   w_buff_din;

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]        r_cnt, w_cnt_nxt;
  logic [N_CLIENTS-1:0]   r_cl_err, w_cl_err_nxt;
`endif

  rr_pick #(
    .N (N_CLIENTS)
  ) u_rr_pick (
    .i_req (i_cl_rd | i_cl_wr),
    .i_ptr (r_rr_ptr),
    .o_hit (w_hit),
    .o_idx (w_pick)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_idx_nxt = r_grant_idx;
    w_grant_oh_nxt  = r_grant_oh;
    w_sd_lba_nxt    = r_sd_lba;
    w_sd_rd_nxt     = r_sd_rd;
    w_sd_wr_nxt     = r_sd_wr;
    w_cl_done_nxt   = '0;
`ifdef SD_ARB_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_cl_err_nxt    = '0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt     = REQ;
          w_grant_idx_nxt = w_pick;
          w_grant_oh_nxt  = N_CLIENTS'(1) << w_pick;
          w_sd_lba_nxt    = i_cl_lba[w_pick*SD_LBA_W +: SD_LBA_W];
          // Read wins when a client raises both request lines.
          w_sd_rd_nxt     = i_cl_rd[w_pick];
          w_sd_wr_nxt     = ~i_cl_rd[w_pick];
`ifdef SD_ARB_TIMEOUT_EN
          w_cnt_nxt       = '0;
`endif
        end
      end
      REQ: begin
        if (i_sd_ack) begin
          w_state_nxt = XFER;
          w_sd_rd_nxt = 1'b0;
          w_sd_wr_nxt = 1'b0;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt    = IDLE;
          w_sd_rd_nxt    = 1'b0;
          w_sd_wr_nxt    = 1'b0;
          w_cl_done_nxt  = r_grant_oh;
          w_cl_err_nxt   = r_grant_oh;
          w_rr_ptr_nxt   = r_grant_idx;
          w_grant_oh_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      XFER: begin
        if (!i_sd_ack) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt    = IDLE;
        w_cl_done_nxt  = r_grant_oh;
        w_rr_ptr_nxt   = r_grant_idx;
        w_grant_oh_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= IdxW'(N_CLIENTS - 1);
      r_grant_idx <= '0;
      r_grant_oh  <= '0;
      r_sd_lba    <= '0;
      r_sd_rd     <= 1'b0;
      r_sd_wr     <= 1'b0;
      r_cl_done   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_grant_oh  <= w_grant_oh_nxt;
      r_sd_lba    <= w_sd_lba_nxt;
      r_sd_rd     <= w_sd_rd_nxt;
      r_sd_wr     <= w_sd_wr_nxt;
      r_cl_done   <= w_cl_done_nxt;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_cnt    <= '0;
      r_cl_err <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_cl_err <= w_cl_err_nxt;
    end
  end
  assign o_cl_err = r_cl_err;
`else
  assign o_cl_err = '0;
`endif

  always_comb begin
    w_buff_din = '0;
    for (int k = 0; k < int'(N_CLIENTS); k++) begin
      if (r_grant_oh[k]) w_buff_din = i_cl_buff_din[k*SD_DATA_W +: SD_DATA_W];
    end
  end

  assign o_sd_buff_din   = w_buff_din;
  assign o_cl_buff_wr    = {N_CLIENTS{i_sd_buff_wr}} & r_grant_oh;
  assign o_cl_din_strobe = {N_CLIENTS{i_sd_din_strobe}} & r_grant_oh;
  assign o_cl_buff_addr  = i_sd_buff_addr;
  assign o_cl_buff_dout  = i_sd_buff_dout;
  assign o_sd_lba        = r_sd_lba;
  assign o_sd_rd         = r_sd_rd;
  assign o_sd_wr         = r_sd_wr;
  assign o_cl_done       = r_cl_done;
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter (two clients); timeout case only when SD_ARB_TIMEOUT_EN.
module tb_sd_sector_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] cl_lba;
  logic [1:0]  cl_rd, cl_wr, cl_done, cl_err, cl_buff_wr, cl_din_strobe;
  logic [8:0]  cl_buff_addr, sd_buff_addr;
  logic [7:0]  cl_buff_dout, sd_buff_dout, sd_buff_din;
  logic [15:0] cl_buff_din;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, sd_din_strobe;

  int n_checks = 0;
  int n_errors = 0;
  int done0 = 0;
  int done1 = 0;
  int wr0_cnt, wr1_cnt, done_snap;

  always #5 clk = ~clk;

  sd_sector_arbiter #(
    .N_CLIENTS      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk_sys       (clk),
    .i_reset_n       (reset_n),
    .i_cl_lba        (cl_lba),
    .i_cl_rd         (cl_rd),
    .i_cl_wr         (cl_wr),
    .o_cl_done       (cl_done),
    .o_cl_err        (cl_err),
    .o_cl_buff_addr  (cl_buff_addr),
    .o_cl_buff_dout  (cl_buff_dout),
    .o_cl_buff_wr    (cl_buff_wr),
    .o_cl_din_strobe (cl_din_strobe),
    .i_cl_buff_din   (cl_buff_din),
    .o_sd_lba        (sd_lba),
    .o_sd_rd         (sd_rd),
    .o_sd_wr         (sd_wr),
    .i_sd_ack        (sd_ack),
    .i_sd_buff_addr  (sd_buff_addr),
    .i_sd_buff_dout  (sd_buff_dout),
    .i_sd_buff_wr    (sd_buff_wr),
    .i_sd_din_strobe (sd_din_strobe),
    .o_sd_buff_din   (sd_buff_din)
  );

  always @(negedge clk) begin
    done0 += int'(cl_done[0]);
    done1 += int'(cl_done[1]);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered one cycle after the grant; drops the client's requests at the done cycle.
  task automatic txn(input int c, input logic [31:0] lba, input logic rd, input string tag);
    chk({tag, " sd_lba"}, sd_lba, lba);
    chk({tag, " sd_rd"}, 32'(sd_rd), 32'(rd));
    chk({tag, " sd_wr"}, 32'(sd_wr), 32'(!rd));
    sd_ack = 1'b1;
    cyc(1);
    chk({tag, " rd dropped"}, 32'(sd_rd | sd_wr), 32'd0);
    sd_ack = 1'b0;
    cyc(1);
    chk({tag, " no early done"}, 32'(cl_done), 32'd0);
    cyc(1);
    chk({tag, " done"}, 32'(cl_done), 32'(2'b01 << c));
    cl_rd[c] = 1'b0;
    cl_wr[c] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cl_lba = '0; cl_rd = '0; cl_wr = '0; cl_buff_din = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    sd_din_strobe = 1'b0;
    cyc(2);
    chk("reset sd_rd", 32'(sd_rd), 32'd0);
    chk("reset sd_wr", 32'(sd_wr), 32'd0);
    chk("reset sd_lba", sd_lba, 32'd0);
    chk("reset done/err", 32'({cl_done, cl_err}), 32'd0);
    reset_n = 1'b1;
    cyc(1);
    sd_buff_wr = 1'b1; sd_din_strobe = 1'b1; sd_ack = 1'b1;
    #1;
    chk("idle strobes ignored", 32'({cl_buff_wr, cl_din_strobe}), 32'd0);
    chk("idle sd_buff_din", 32'(sd_buff_din), 32'd0);
    sd_buff_wr = 1'b0; sd_din_strobe = 1'b0; sd_ack = 1'b0;
    cyc(1);
    chk("idle ack no done", 32'(cl_done), 32'd0);

    // Single read on client 0, ack after 5 cycles, 512 buffer writes.
    cl_lba[31:0] = 32'h0000_1234; cl_rd = 2'b01;
    cyc(1);
    chk("t1 sd_lba", sd_lba, 32'h0000_1234);
    chk("t1 sd_rd", 32'(sd_rd), 32'd1);
    cyc(4);
    chk("t1 sd_rd held", 32'(sd_rd), 32'd1);
    sd_ack = 1'b1;
    cyc(1);
    chk("t1 rd drop after ack", 32'(sd_rd), 32'd0);
    cl_rd = 2'b00;
    wr0_cnt = 0; wr1_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = 8'(i ^ 8'h5A);
      #1;
      wr0_cnt += int'(cl_buff_wr[0]);
      wr1_cnt += int'(cl_buff_wr[1]);
      if (i == 300) begin
        chk("t1 addr bcast", 32'(cl_buff_addr), 32'd300);
        chk("t1 dout bcast", 32'(cl_buff_dout), 32'(8'(300 ^ 8'h5A)));
      end
      cyc(1);
      sd_buff_wr = 1'b0;
      cyc(1);
    end
    chk("t1 cl_buff_wr0 count", 32'(wr0_cnt), 32'd512);
    chk("t1 cl_buff_wr1 count", 32'(wr1_cnt), 32'd0);
    sd_ack = 1'b0;
    cyc(1);
    chk("t1 done f+1", 32'(cl_done), 32'd0);
    cyc(1);
    chk("t1 done f+2", 32'(cl_done), 32'b01);
    cyc(1);
    chk("t1 done single", 32'(cl_done), 32'd0);

    // Contention from reset: 0,1 then 0,1 again.
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cl_lba = {32'hBBBB_0001, 32'hAAAA_0000}; cl_rd = 2'b11;
    cyc(1);
    txn(0, 32'hAAAA_0000, 1'b1, "c1 first");
    cyc(1);
    txn(1, 32'hBBBB_0001, 1'b1, "c1 second");
    cl_rd = 2'b11;
    cyc(1);
    txn(0, 32'hAAAA_0000, 1'b1, "c2 first");
    cyc(1);
    txn(1, 32'hBBBB_0001, 1'b1, "c2 second");

    // Write on client 1 with data mux and strobe routing.
    cl_lba[63:32] = 32'h0000_5678; cl_buff_din = 16'hA5_3C; cl_wr = 2'b10;
    cyc(1);
    chk("w sd_wr", 32'(sd_wr), 32'd1);
    chk("w sd_rd", 32'(sd_rd), 32'd0);
    chk("w sd_lba", sd_lba, 32'h0000_5678);
    sd_ack = 1'b1;
    cyc(1);
    chk("w din xfer", 32'(sd_buff_din), 32'hA5);
    sd_din_strobe = 1'b1;
    #1;
    chk("w din_strobe on", 32'(cl_din_strobe), 32'b10);
    sd_din_strobe = 1'b0;
    #1;
    chk("w din_strobe off", 32'(cl_din_strobe), 32'd0);
    cyc(1);
    chk("w din later", 32'(sd_buff_din), 32'hA5);
    sd_ack = 1'b0;
    cyc(2);
    chk("w done", 32'(cl_done), 32'b10);
    cl_wr = 2'b00;
    chk("w din idle", 32'(sd_buff_din), 32'd0);

    // Read+write together is a read; request dropped during REQ still completes.
    cl_rd = 2'b01; cl_wr = 2'b01;
    cyc(1);
    chk("rw sd_rd", 32'(sd_rd), 32'd1);
    chk("rw sd_wr", 32'(sd_wr), 32'd0);
    cl_rd = 2'b00; cl_wr = 2'b00;
    cyc(2);
    chk("drop sd_rd held", 32'(sd_rd), 32'd1);
    txn(0, 32'hAAAA_0000, 1'b1, "drop");

    // Reset during XFER: everything clears, no done, client 0 first afterwards.
    cyc(1);
    cl_rd = 2'b10;
    cyc(1);
    chk("rx grant1", 32'(sd_rd), 32'd1);
    cl_rd = 2'b00;
    sd_ack = 1'b1;
    cyc(1);
    sd_buff_wr = 1'b1; sd_din_strobe = 1'b1;
    #1;
    chk("rx routed", 32'(cl_buff_wr), 32'b10);
    done_snap = done0 + done1;
    reset_n = 1'b0;
    cyc(1);
    chk("rx sd_rd/wr", 32'({sd_rd, sd_wr}), 32'd0);
    chk("rx strobes", 32'({cl_buff_wr, cl_din_strobe}), 32'd0);
    chk("rx done", 32'(cl_done), 32'd0);
    sd_buff_wr = 1'b0; sd_din_strobe = 1'b0; sd_ack = 1'b0;
    cl_rd = 2'b11;
    reset_n = 1'b1;
    cyc(3);
    chk("rx no done emitted", 32'(done0 + done1), 32'(done_snap));
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    txn(0, 32'hAAAA_0000, 1'b1, "rx after");
    cl_rd = 2'b00;
    cyc(2);

    // Stuck request: timeout if built in, otherwise waits indefinitely.
    cl_rd = 2'b01;
    cyc(1);
    chk("to sd_rd", 32'(sd_rd), 32'd1);
`ifdef SD_ARB_TIMEOUT_EN
    cyc(15);
    chk("to cycle16 rd", 32'(sd_rd), 32'd1);
    cl_rd = 2'b00;
    cyc(1);
    chk("to rd drop", 32'(sd_rd), 32'd0);
    chk("to done", 32'(cl_done), 32'b01);
    chk("to err", 32'(cl_err), 32'b01);
    cyc(1);
    chk("to pulse end", 32'({cl_done, cl_err}), 32'd0);
`else
    cyc(1000);
    chk("no-to sd_rd held", 32'(sd_rd), 32'd1);
    chk("no-to err", 32'(cl_err), 32'd0);
    txn(0, 32'hAAAA_0000, 1'b1, "no-to finish");
`endif
    cyc(2);
    chk("done0 total", 32'(done0), 32'd6);
    chk("done1 total", 32'(done1), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
